alu_result_queue: RTL and testbench

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

---
 rtl/alu_pkg.sv | 36 +++
 rtl/result_queue_mem.sv | 26 ++
 rtl/alu_result_queue.sv | 85 ++++++++
 tb/tb_alu_result_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU result types: operation codes, the stored queue entry and the
// divide-by-zero result word.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef struct packed {
    logic        err;
    op_e         op;
    logic [31:0] data;
  } entry_t;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  // A divide with a zero divisor is replaced by the all-ones word and flagged.
  function automatic entry_t make_entry(input logic [1:0]  sel,
                                        input logic [31:0] result,
                                        input logic [31:0] b);
    entry_t e;
    e.op = op_e'(sel);
    if ((op_e'(sel) == OP_DIV) && (b == 32'd0)) begin
      e.data = DIV0_RESULT;
      e.err  = 1'b1;
    end else begin
      e.data = result;
      e.err  = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/result_queue_mem.sv
// Entry storage for the ALU result queue: one synchronous write port and one
// asynchronous read port, contents are deliberately not reset.
module result_queue_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with divide-by-zero substitution on entry; pointers,
// occupancy and handshake flags live here, storage in result_queue_mem.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [1:0]                 in_sel,
  input  logic [31:0]                in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [1:0]                 out_op,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("alu_result_queue: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_r;
  logic          push;
  logic          pop;
  entry_t        wentry;
  entry_t        rentry;

  // Full blocks a push even when a pop happens in the same cycle.
  assign in_ready  = (count_r != CW'(DEPTH));
  assign out_valid = (count_r != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_r;

  always_comb begin
    wentry = make_entry(in_sel, in_result, in_b);
  end

  result_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (rentry)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        count_r <= count_r + CW'(1);
      end else if (!push && pop) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  assign out_data = out_valid ? rentry.data       : 32'd0;
  assign out_op   = out_valid ? 2'(rentry.op)     : 2'd0;
  assign out_err  = out_valid ? rentry.err        : 1'b0;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_result = 32'd0;
  logic [1:0]    in_sel = 2'd0;
  logic [31:0]   in_b = 32'd1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [1:0]    out_op;
  logic          out_err;
  logic [CW-1:0] count;

  int   checks   = 0;
  int   failures = 0;
  bit   run      = 1'b0;
  exp_t mq[$];

  alu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_sel    (in_sel),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_err   (out_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model decides push/pop from the inputs held before it.
  task automatic cycle();
    bit   push;
    bit   pop;
    exp_t e;
    push   = in_valid && (mq.size() < DEPTH);
    pop    = out_ready && (mq.size() != 0);
    e.op   = in_sel;
    e.err  = (in_sel == 2'd3) && (in_b == 32'd0);
    e.data = e.err ? 32'hFFFF_FFFF : in_result;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    #1;
  endtask

  task automatic push_one(input logic [31:0] r, input logic [1:0] s, input logic [31:0] b);
    in_valid = 1'b1; in_result = r; in_sel = s; in_b = b;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (mq.size() != 0) cycle();
    out_ready = 1'b0;
  endtask

  // Compare process: every settled cycle the DUT must match the model.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].data);
        chk("out_op", 32'(out_op), 32'(mq[0].op));
        chk("out_err", 32'(out_err), 32'(mq[0].err));
      end else begin
        chk("idle_data", out_data, 32'd0);
        chk("idle_op", 32'(out_op), 32'd0);
        chk("idle_err", 32'(out_err), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] v;
    // Reset state
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;

    // Add result 5, accepted on the first edge after reset
    push_one(32'd5, 2'd0, 32'd3);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_data", out_data, 32'd5);
    chk("add_op", 32'(out_op), 32'd0);
    chk("add_err", 32'(out_err), 32'd0);
    chk("add_count", 32'(count), 32'd1);
    drain();

    // Divide by zero, then a legal divide pushed while popping
    push_one($urandom, 2'd3, 32'd0);
    chk("div0_data", out_data, 32'hFFFF_FFFF);
    chk("div0_op", 32'(out_op), 32'd3);
    chk("div0_err", 32'(out_err), 32'd1);
    out_ready = 1'b1;
    push_one(32'd7, 2'd3, 32'd2);
    out_ready = 1'b0;
    chk("div_data", out_data, 32'd7);
    chk("div_err", 32'(out_err), 32'd0);
    chk("div_count", 32'(count), 32'd1);
    drain();

    // Push and pop together while empty: only the push happens
    out_ready = 1'b1;
    push_one(32'd42, 2'd1, 32'd0);
    out_ready = 1'b0;
    chk("empty_pp_count", 32'(count), 32'd1);
    chk("empty_pp_data", out_data, 32'd42);
    drain();

    // Fill, ignored fifth push, ordered drain
    for (int i = 1; i <= 4; i++) push_one(32'(i), 2'd2, 32'd1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push_one(32'd5, 2'd0, 32'd1);
    chk("full_ignore_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_data, 32'(i));
      cycle();
    end
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Full with push and pop together: pop only, then push accepted
    for (int i = 1; i <= 4; i++) push_one(32'(i), 2'd0, 32'd1);
    out_ready = 1'b1;
    push_one(32'd9, 2'd0, 32'd1);
    out_ready = 1'b0;
    chk("full_pp_count", 32'(count), 32'd3);
    push_one(32'd9, 2'd0, 32'd1);
    chk("full_refill_count", 32'(count), 32'd4);
    chk("full_refill_head", out_data, 32'd2);
    drain();

    // Streaming 10..19 with occupancy steady at one, across pointer wrap
    push_one(32'd10, 2'd0, 32'd1);
    out_ready = 1'b1;
    for (int v2 = 11; v2 <= 19; v2++) begin
      chk("stream_head", out_data, 32'(v2 - 1));
      push_one(32'(v2), 2'd0, 32'd1);
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_last", out_data, 32'd19);
    cycle();
    out_ready = 1'b0;
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with three entries stored
    for (int i = 0; i < 3; i++) push_one(32'(100 + i), 2'd0, 32'd1);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    mq.delete();
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    push_one(32'hABC, 2'd1, 32'd0);
    chk("fresh_count", 32'(count), 32'd1);
    chk("fresh_data", out_data, 32'hABC);
    chk("fresh_op", 32'(out_op), 32'd1);
    drain();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      v         = $urandom;
      in_result = v;
      in_b      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cycle();
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
